// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned REG_AW      = 5;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned DEF_TIMEOUT = 255;

  // Low address bits that must be zero for a word access.
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'h0000_0003;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // Payload captured when an access is accepted.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } dmem_cmd_t;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return |(addr & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/dmem_handshake.sv
// Data-memory req/ack sequencer: access FSM, timeout counter and the
// registered request / response fields.
module dmem_handshake
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  dmem_cmd_t       cmd_i,
  input  logic            dmem_ack_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output mem_state_e      state_o,
  output logic            err_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o
);

  // Counter value seen on the last permitted WAIT cycle.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic             err_q, err_d;

  // State and request registers; reset drops the request immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: accept, wait for ack or timeout (ack wins), report.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d  = cmd_i.addr;
          wdata_d = cmd_i.wdata;
          we_d    = cmd_i.we;
          req_d   = 1'b1;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_ack_i) begin
          rdata_d = we_q ? '0 : dmem_rdata_i;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == LAST_CNT) begin
          rdata_d = '0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        req_d   = 1'b0;
        we_d    = 1'b0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign state_o      = state_q;
  assign err_o        = err_q;
  assign rdata_o      = rdata_q;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: forwards EX/MEM fields to MEMWB, runs loads/stores
// through dmem_handshake and stalls upstream while an access is pending.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [XLEN-1:0]   iInstr,
  input  logic              iRegWrite,
  input  logic              iMemToReg,
  input  logic              iMemRead,
  input  logic              iMemWrite,
  input  logic [XLEN-1:0]   iALUResult,
  input  logic [XLEN-1:0]   iWriteData,
  input  logic [REG_AW-1:0] iwriteRegWire,
  input  logic              ivalid,
  output logic [XLEN-1:0]   oInstr,
  output logic              oRegWrite,
  output logic              oMemToReg,
  output logic [XLEN-1:0]   oALUResult,
  output logic [REG_AW-1:0] owriteRegWire,
  output logic [XLEN-1:0]   oouputData,
  output logic              ovalid,
  output logic              oerr,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata
);

  logic       is_mem, is_mis, start;
  mem_state_e state;
  logic       acc_err;
  logic [XLEN-1:0] acc_rdata;
  dmem_cmd_t  cmd;

  assign is_mem = ivalid & (iMemRead | iMemWrite);
  assign is_mis = is_mem & is_misaligned(iALUResult);
  assign start  = is_mem & ~is_mis;

  assign cmd.we    = iMemWrite;
  assign cmd.addr  = iALUResult;
  assign cmd.wdata = iWriteData;

  dmem_handshake #(
    .TIMEOUT (TIMEOUT)
  ) u_hs (
    .clk_i        (clock),
    .rst_ni       (reset),
    .start_i      (start),
    .cmd_i        (cmd),
    .dmem_ack_i   (dmem_ack),
    .dmem_rdata_i (dmem_rdata),
    .state_o      (state),
    .err_o        (acc_err),
    .rdata_o      (acc_rdata),
    .dmem_req_o   (dmem_req),
    .dmem_we_o    (dmem_we),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata)
  );

  // MEMWB payload, stall and error; inputs are held upstream during a stall.
  always_comb begin
    oInstr        = iInstr;
    oRegWrite     = iRegWrite;
    oMemToReg     = iMemToReg;
    oALUResult    = iALUResult;
    owriteRegWire = iwriteRegWire;
    oouputData    = '0;
    ovalid        = ivalid;
    oerr          = 1'b0;
    stall         = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (is_mis) begin
          oRegWrite = 1'b0;
          oerr      = 1'b1;
        end else if (is_mem) begin
          stall  = 1'b1;
          ovalid = 1'b0;
        end
      end
      ST_WAIT: begin
        stall  = 1'b1;
        ovalid = 1'b0;
      end
      ST_DONE: begin
        oouputData = acc_rdata;
        if (acc_err) begin
          oRegWrite = 1'b0;
          oerr      = 1'b1;
        end
      end
      default: begin
        ovalid = 1'b0;
      end
    endcase

    if (!reset) begin
      stall  = 1'b0;
      ovalid = 1'b0;
      oerr   = 1'b0;
    end
  end

endmodule
